// File: rtl/console_terminal.sv
// console_terminal
// Character-cell text buffer with a streaming byte write port. A producer
// pushes bytes (printable or CR/LF/BS/FF) which are placed at a hardware
// cursor with auto-wrap and hardware scroll. The display side converts the
// current pixel position into a cell lookup for the downstream renderer.
// Scrolling rotates a top-row pointer instead of moving memory contents.
//
// Ports:
//   clk_pixel   sole clock (pixel clock)
//   RESETn      asynchronous active-low reset
//   in_char     byte to write or control code
//   in_attr     attribute stored with a printable byte
//   in_valid    producer has a byte
//   in_ready    block accepts a byte this cycle (registered)
//   cx, cy      current pixel position
//   character   glyph code for the pixel position sampled one cycle earlier
//   attribute   attribute for the pixel position sampled one cycle earlier
//   cursor_col  current cursor column
//   cursor_row  current cursor row (logical, 0 = top of screen)
module console_terminal #(
    parameter int          COLS         = 80,
    parameter int          ROWS         = 30,
    parameter logic [7:0]  DEFAULT_ATTR = 8'h0F
) (
    input  logic                      clk_pixel,
    input  logic                      RESETn,
    input  logic [7:0]                in_char,
    input  logic [7:0]                in_attr,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [9:0]                cx,
    input  logic [9:0]                cy,
    output logic [7:0]                character,
    output logic [7:0]                attribute,
    output logic [$clog2(COLS)-1:0]   cursor_col,
    output logic [$clog2(ROWS)-1:0]   cursor_row
);

    localparam int COL_W  = $clog2(COLS);
    localparam int ROW_W  = $clog2(ROWS);
    localparam int CELLS  = COLS * ROWS;
    localparam int ADDR_W = $clog2(CELLS);
    localparam logic [15:0] BLANK_WORD = {DEFAULT_ATTR, 8'h20};

    typedef enum logic [1:0] {
        ST_CLEAR  = 2'd0,
        ST_IDLE   = 2'd1,
        ST_SCROLL = 2'd2
    } state_t;

    // Logical row -> physical row through the rotating top pointer.
    // Both operands are < ROWS, so one conditional subtract suffices.
    function automatic logic [ROW_W-1:0] map_row(input logic [ROW_W-1:0] lrow,
                                                  input logic [ROW_W-1:0] top);
        logic [ROW_W:0] sum;
        sum = {1'b0, lrow} + {1'b0, top};
        if (sum >= (ROW_W+1)'(ROWS)) begin
            sum = sum - (ROW_W+1)'(ROWS);
        end else begin
            sum = sum;
        end
        return sum[ROW_W-1:0];
    endfunction

    // Physical (row, col) -> linear memory address.
    function automatic logic [ADDR_W-1:0] cell_addr(input logic [ROW_W-1:0] prow,
                                                     input logic [COL_W-1:0] col);
        return ADDR_W'(prow) * ADDR_W'(COLS) + ADDR_W'(col);
    endfunction

    state_t               state_r;
    state_t               state_n_s;
    logic                 in_ready_r;
    logic [COL_W-1:0]     col_r;
    logic [ROW_W-1:0]     row_r;
    logic [ROW_W-1:0]     top_r;
    logic [ROW_W-1:0]     scroll_row_r;
    logic [ADDR_W-1:0]    cnt_r;
    logic [15:0]          rd_word_r;

    logic [15:0]          mem [0:CELLS-1];

    logic                 accept_s;
    logic                 is_cr_s;
    logic                 is_lf_s;
    logic                 is_bs_s;
    logic                 is_ff_s;
    logic                 col_last_s;
    logic                 row_last_s;
    logic                 scroll_req_s;
    logic                 fill_done_s;
    logic [ROW_W-1:0]     top_next_s;
    logic                 wr_en_s;
    logic [ADDR_W-1:0]    wr_addr_s;
    logic [15:0]          wr_data_s;
    logic                 rd_in_range_s;
    logic [ADDR_W-1:0]    rd_addr_s;

    assign accept_s   = in_valid && in_ready_r;
    assign is_cr_s    = (in_char == 8'h0D);
    assign is_lf_s    = (in_char == 8'h0A);
    assign is_bs_s    = (in_char == 8'h08);
    assign is_ff_s    = (in_char == 8'h0C);
    assign col_last_s = (col_r == COL_W'(COLS - 1));
    assign row_last_s = (row_r == ROW_W'(ROWS - 1));
    assign top_next_s = (top_r == ROW_W'(ROWS - 1)) ? {ROW_W{1'b0}} : top_r + ROW_W'(1);

    // A transfer that advances past the bottom row starts a scroll: either LF,
    // or a printable byte landing in the last column.
    assign scroll_req_s = accept_s && row_last_s &&
                          (is_lf_s || (!is_cr_s && !is_bs_s && !is_ff_s && col_last_s));

    assign in_ready   = in_ready_r;
    assign cursor_col = col_r;
    assign cursor_row = row_r;
    assign character  = rd_word_r[7:0];
    assign attribute  = rd_word_r[15:8];

    // Fill sequence completion for the current busy state.
    always_comb begin
        fill_done_s = 1'b0;
        case (state_r)
            ST_CLEAR:  fill_done_s = (cnt_r == ADDR_W'(CELLS - 1));
            ST_SCROLL: fill_done_s = (cnt_r == ADDR_W'(COLS - 1));
            default:   fill_done_s = 1'b0;
        endcase
    end

    // State register; in_ready is registered as a decode of the next state.
    always_ff @(posedge clk_pixel or negedge RESETn) begin
        if (!RESETn) begin
            state_r    <= ST_CLEAR;
            in_ready_r <= 1'b0;
        end else begin
            state_r    <= state_n_s;
            in_ready_r <= (state_n_s == ST_IDLE);
        end
    end

    // Next-state logic.
    always_comb begin
        state_n_s = state_r;
        case (state_r)
            ST_CLEAR: begin
                if (fill_done_s) state_n_s = ST_IDLE;
                else             state_n_s = ST_CLEAR;
            end
            ST_IDLE: begin
                if (accept_s && is_ff_s) state_n_s = ST_CLEAR;
                else if (scroll_req_s)   state_n_s = ST_SCROLL;
                else                     state_n_s = ST_IDLE;
            end
            ST_SCROLL: begin
                if (fill_done_s) state_n_s = ST_IDLE;
                else             state_n_s = ST_SCROLL;
            end
            default: state_n_s = ST_CLEAR;
        endcase
    end

    // Memory write port selection per state.
    always_comb begin
        wr_en_s   = 1'b0;
        wr_addr_s = {ADDR_W{1'b0}};
        wr_data_s = BLANK_WORD;
        case (state_r)
            ST_CLEAR: begin
                wr_en_s   = 1'b1;
                wr_addr_s = cnt_r;
                wr_data_s = BLANK_WORD;
            end
            ST_SCROLL: begin
                wr_en_s   = 1'b1;
                wr_addr_s = cell_addr(scroll_row_r, COL_W'(cnt_r));
                wr_data_s = BLANK_WORD;
            end
            ST_IDLE: begin
                wr_en_s   = accept_s && !is_cr_s && !is_lf_s && !is_bs_s && !is_ff_s;
                wr_addr_s = cell_addr(map_row(row_r, top_r), col_r);
                wr_data_s = {in_attr, in_char};
            end
            default: begin
                wr_en_s   = 1'b0;
                wr_addr_s = {ADDR_W{1'b0}};
                wr_data_s = BLANK_WORD;
            end
        endcase
    end

    // Cursor, top-row pointer and fill counter.
    always_ff @(posedge clk_pixel or negedge RESETn) begin
        if (!RESETn) begin
            col_r        <= {COL_W{1'b0}};
            row_r        <= {ROW_W{1'b0}};
            top_r        <= {ROW_W{1'b0}};
            scroll_row_r <= {ROW_W{1'b0}};
            cnt_r        <= {ADDR_W{1'b0}};
        end else begin
            case (state_r)
                ST_CLEAR, ST_SCROLL: begin
                    if (fill_done_s) cnt_r <= {ADDR_W{1'b0}};
                    else             cnt_r <= cnt_r + ADDR_W'(1);
                end
                ST_IDLE: begin
                    if (accept_s) begin
                        if (is_ff_s) begin
                            col_r <= {COL_W{1'b0}};
                            row_r <= {ROW_W{1'b0}};
                            top_r <= {ROW_W{1'b0}};
                            cnt_r <= {ADDR_W{1'b0}};
                        end else if (is_bs_s) begin
                            if (col_r != {COL_W{1'b0}}) col_r <= col_r - COL_W'(1);
                            else                        col_r <= col_r;
                        end else if (is_cr_s) begin
                            col_r <= {COL_W{1'b0}};
                        end else if (is_lf_s || col_last_s) begin
                            // Row advance; on the bottom row rotate the screen and
                            // remember which physical row must be blanked.
                            col_r <= {COL_W{1'b0}};
                            if (!row_last_s) begin
                                row_r <= row_r + ROW_W'(1);
                            end else begin
                                top_r        <= top_next_s;
                                scroll_row_r <= top_r;
                                cnt_r        <= {ADDR_W{1'b0}};
                            end
                        end else begin
                            col_r <= col_r + COL_W'(1);
                        end
                    end else begin
                        col_r <= col_r;
                    end
                end
                default: begin
                    cnt_r <= {ADDR_W{1'b0}};
                end
            endcase
        end
    end

    // Character memory write port.
    always_ff @(posedge clk_pixel) begin
        if (wr_en_s) begin
            mem[wr_addr_s] <= wr_data_s;
        end
    end

    // Display-side address: cell under the pixel, mapped through top_r.
    always_comb begin
        rd_in_range_s = (cx < 10'(COLS * 8)) && (cy < 10'(ROWS * 16));
        if (rd_in_range_s) begin
            rd_addr_s = cell_addr(map_row(ROW_W'(cy[8:4]), top_r), COL_W'(cx[9:3]));
        end else begin
            rd_addr_s = {ADDR_W{1'b0}};
        end
    end

    // Registered read port; out-of-range pixels yield zero.
    always_ff @(posedge clk_pixel or negedge RESETn) begin
        if (!RESETn) begin
            rd_word_r <= 16'h0000;
        end else if (rd_in_range_s) begin
            rd_word_r <= mem[rd_addr_s];
        end else begin
            rd_word_r <= 16'h0000;
        end
    end

endmodule

// File: tb/tb_console_terminal.sv
module tb_console_terminal;

    logic       clk_pixel = 1'b0;
    logic       RESETn    = 1'b0;
    logic [7:0] in_char   = 8'h00;
    logic [7:0] in_attr   = 8'h00;
    logic       in_valid  = 1'b0;
    logic       in_ready;
    logic [9:0] cx        = 10'd0;
    logic [9:0] cy        = 10'd0;
    logic [7:0] character;
    logic [7:0] attribute;
    logic [6:0] cursor_col;
    logic [4:0] cursor_row;

    int n_checks    = 0;
    int n_fail      = 0;
    int ready_drops = 0;

    console_terminal dut (
        .clk_pixel  (clk_pixel),
        .RESETn     (RESETn),
        .in_char    (in_char),
        .in_attr    (in_attr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .cx         (cx),
        .cy         (cy),
        .character  (character),
        .attribute  (attribute),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row)
    );

    always #5 clk_pixel = ~clk_pixel;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One-cycle transfer; notes whether in_ready was low when offered.
    task automatic send(input logic [7:0] c, input logic [7:0] a);
        @(negedge clk_pixel);
        in_char  = c;
        in_attr  = a;
        in_valid = 1'b1;
        if (in_ready !== 1'b1) ready_drops++;
        @(posedge clk_pixel);
        #1;
        in_valid = 1'b0;
    endtask

    // Counts rising edges until in_ready is seen high (bounded).
    task automatic wait_ready(output int cycles);
        cycles = 0;
        while (in_ready !== 1'b1 && cycles < 6000) begin
            @(posedge clk_pixel);
            #1;
            cycles++;
        end
    endtask

    task automatic read_px(input int px, input int py, output logic [7:0] ch, output logic [7:0] at);
        @(negedge clk_pixel);
        cx = 10'(px);
        cy = 10'(py);
        @(negedge clk_pixel);
        ch = character;
        at = attribute;
    endtask

    task automatic read_cell(input int col, input int row, output logic [7:0] ch, output logic [7:0] at);
        read_px(col * 8, row * 16, ch, at);
    endtask

    task automatic blank_scan(output int bad);
        logic [7:0] ch;
        logic [7:0] at;
        bad = 0;
        for (int r = 0; r < 30; r++) begin
            for (int c = 0; c < 80; c++) begin
                read_cell(c, r, ch, at);
                if (ch !== 8'h20 || at !== 8'h0F) bad++;
            end
        end
    endtask

    initial begin
        int cycles;
        int bad;
        logic [7:0] ch;
        logic [7:0] at;

        // Reset values
        #12;
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_character", character, 8'h00);
        check("rst_attribute", attribute, 8'h00);
        check("rst_cursor_col", cursor_col, 7'd0);
        check("rst_cursor_row", cursor_row, 5'd0);

        // Release: full clear
        @(negedge clk_pixel);
        RESETn = 1'b1;
        wait_ready(cycles);
        check("reset_clear_busy", cycles, 2400);
        blank_scan(bad);
        check("reset_blank_cells", bad, 0);
        read_px(700, 0, ch, at);
        check("oor_x_char", ch, 8'h00);
        check("oor_x_attr", at, 8'h00);
        read_px(0, 480, ch, at);
        check("oor_y_char", ch, 8'h00);

        // "AB"
        send(8'h41, 8'h1E);
        send(8'h42, 8'h1E);
        check("ab_cursor_col", cursor_col, 7'd2);
        check("ab_cursor_row", cursor_row, 5'd0);
        read_cell(0, 0, ch, at);
        check("a_char", ch, 8'h41);
        check("a_attr", at, 8'h1E);
        read_px(8, 0, ch, at);
        check("b_char", ch, 8'h42);
        check("b_attr", at, 8'h1E);

        // CR then one full row of 'x' wraps to the next row
        send(8'h0D, 8'h00);
        check("cr_col", cursor_col, 7'd0);
        for (int i = 0; i < 80; i++) send(8'h78, 8'h07);
        check("wrap_col", cursor_col, 7'd0);
        check("wrap_row", cursor_row, 5'd1);
        check("wrap_ready_drops", ready_drops, 0);
        read_cell(0, 0, ch, at);
        check("x_first_char", ch, 8'h78);
        read_cell(79, 0, ch, at);
        check("x_last_char", ch, 8'h78);
        check("x_last_attr", at, 8'h07);

        // Marker on row 1, then CR / BS at column 0 / LF
        send(8'h4D, 8'h2A);
        check("m_col", cursor_col, 7'd1);
        send(8'h0D, 8'h00);
        check("cr2_col", cursor_col, 7'd0);
        send(8'h08, 8'h00);
        check("bs_at_zero_col", cursor_col, 7'd0);
        send(8'h0A, 8'h00);
        check("lf_col", cursor_col, 7'd0);
        check("lf_row", cursor_row, 5'd2);

        // BS mid-row moves back without erasing
        send(8'h71, 8'h07);
        send(8'h72, 8'h07);
        send(8'h08, 8'h00);
        check("bs_col", cursor_col, 7'd1);
        read_cell(1, 2, ch, at);
        check("bs_no_erase", ch, 8'h72);
        send(8'h0D, 8'h00);
        send(8'h0A, 8'h00);
        for (int i = 0; i < 26; i++) send(8'h0A, 8'h00);
        check("bottom_row", cursor_row, 5'd29);
        check("no_early_scroll_drops", ready_drops, 0);

        // Scroll
        send(8'h5A, 8'h55);
        send(8'h0A, 8'h00);
        wait_ready(cycles);
        check("scroll_busy", cycles, 80);
        check("scroll_row", cursor_row, 5'd29);
        check("scroll_col", cursor_col, 7'd0);
        read_cell(0, 0, ch, at);
        check("scrolled_row0_char", ch, 8'h4D);
        check("scrolled_row0_attr", at, 8'h2A);
        read_cell(1, 1, ch, at);
        check("scrolled_row1_char", ch, 8'h72);
        read_cell(0, 28, ch, at);
        check("scrolled_row28_char", ch, 8'h5A);
        read_px(0, 464, ch, at);
        check("new_bottom_char", ch, 8'h20);
        check("new_bottom_attr", at, 8'h0F);
        read_cell(79, 29, ch, at);
        check("new_bottom_last_char", ch, 8'h20);
        send(8'h57, 8'h33);
        read_cell(0, 29, ch, at);
        check("write_after_scroll_char", ch, 8'h57);
        check("write_after_scroll_attr", at, 8'h33);

        // Form feed mid-screen
        send(8'h0C, 8'h00);
        check("ff_col", cursor_col, 7'd0);
        check("ff_row", cursor_row, 5'd0);
        wait_ready(cycles);
        check("ff_busy", cycles, 2400);
        blank_scan(bad);
        check("ff_blank_cells", bad, 0);

        // Reset in the middle of a scroll
        for (int i = 0; i < 29; i++) send(8'h0A, 8'h00);
        check("pre_reset_row", cursor_row, 5'd29);
        @(negedge clk_pixel);
        cx = 10'd0;
        cy = 10'd0;
        send(8'h0A, 8'h00);
        check("in_scroll_ready", in_ready, 1'b0);
        check("pre_reset_char", character, 8'h20);
        repeat (5) @(posedge clk_pixel);
        #3;
        RESETn = 1'b0;
        #1;
        check("async_rst_in_ready", in_ready, 1'b0);
        check("async_rst_char", character, 8'h00);
        check("async_rst_attr", attribute, 8'h00);
        check("async_rst_row", cursor_row, 5'd0);
        check("async_rst_col", cursor_col, 7'd0);
        @(negedge clk_pixel);
        @(negedge clk_pixel);
        RESETn = 1'b1;
        wait_ready(cycles);
        check("rerelease_clear_busy", cycles, 2400);
        read_cell(0, 29, ch, at);
        check("rerelease_blank_char", ch, 8'h20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
